float_result_pair: RTL
======================

FLOAT_RESULT_PAIR -- requirements
Module: float_result_pair

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per channel FIFO; must be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port s_axis_r1_tvalid, input, 1, channel-1 result valid from adder 1.
REQ-005 SHALL have port s_axis_r1_tdata, input, 32, channel-1 FP32 result.
REQ-006 SHALL have port s_axis_r1_tready, output, 1, channel-1 accept.
REQ-007 SHALL have ports s_axis_r2_tvalid, s_axis_r2_tdata and s_axis_r2_tready with the same directions, widths and meanings as REQ-004 to REQ-006, for channel 2.
REQ-008 SHALL have port m_axis_pair_tvalid, output, 1, paired result valid.
REQ-009 SHALL have port m_axis_pair_tdata, output, 64, {r2, r1}: bits [31:0] = r1, bits [63:32] = r2.
REQ-010 SHALL have port m_axis_pair_tready, input, 1, downstream accept.
REQ-011 SHALL have port m_axis_pair_tuser, output, 1, NaN flag (see Configuration).
REQ-012 SHALL have port pair_count, output, 16, number of delivered pairs.
REQ-013 SHALL have port skew_err, output, 1, sticky channel-imbalance flag.

Function
REQ-014 SHALL give each channel an independent FIFO of DEPTH entries with an occupancy counter of width $clog2(DEPTH)+1.
REQ-015 SHALL drive s_axis_rN_tready = rst_n AND NOT fullN, where full means occupancy equals DEPTH; there is no pass-through write when full, even on a simultaneous pop.
REQ-016 SHALL push channel N exactly on a cycle where s_axis_rN_tvalid and s_axis_rN_tready are both high.
REQ-017 SHALL drive m_axis_pair_tvalid high iff both FIFOs are non-empty, and drive m_axis_pair_tdata combinationally from the two FIFO heads.
REQ-018 SHALL pop both FIFOs together on a cycle where m_axis_pair_tvalid and m_axis_pair_tready are both high; it never pops a single FIFO.
REQ-019 SHALL hold m_axis_pair_tdata stable while tvalid is high and tready is low.
REQ-020 SHALL have latency of one cycle: a push at edge N with the other FIFO already non-empty gives tvalid high after edge N.
REQ-021 SHALL, on a simultaneous push and pop on the same FIFO, keep its occupancy unchanged and advance both pointers.
REQ-022 SHALL wrap pointers modulo DEPTH.
REQ-023 SHALL increment pair_count by 1 per pop and wrap from 16'hFFFF to 0.
REQ-024 SHALL set skew_err when one FIFO is full while the other is empty; the flag is cleared only by reset.
REQ-025 SHALL pass data bit-exact; no arithmetic is applied to the results.

Reset
REQ-026 SHALL, while rst_n is low at a clock edge, clear pointers, occupancies, pair_count and skew_err, and discard FIFO contents; this includes a reset asserted mid-operation.
REQ-027 SHALL hold m_axis_pair_tvalid=0, m_axis_pair_tuser=0 and both s_axis tready=0 during reset.
REQ-028 SHALL drive both s_axis tready to 1 in the first cycle after reset is released.

Configuration
REQ-029 SHALL, with macro FLOAT_PAIR_NAN_FLAG_EN defined, drive m_axis_pair_tuser high when either head is NaN (exponent 8'hFF and mantissa non-zero).
REQ-030 SHALL, without FLOAT_PAIR_NAN_FLAG_EN, tie m_axis_pair_tuser to 0 and contain no NaN logic.

Structure
REQ-031 SHALL take FP32_W=32, FP32_EXP_MSB/LSB, FP32_EXP_ALL1=8'hFF and a function is_nan() from shared package float_pkg.
REQ-032 SHALL implement each channel FIFO as an instance of one sub-module, float_stream_fifo (parameters DEPTH and WIDTH), instantiated twice.

Verification
REQ-033 SHALL cover: r1=32'h3F800000 at cycle 0, r2=32'h40000000 at cycle 3, tready=1 -> tvalid first high after cycle-3 edge, tdata=64'h40000000_3F800000, pair_count=1.
REQ-034 SHALL cover: DEPTH=4, five r1 pushes with no r2 -> s_axis_r1_tready low after the fourth accept, skew_err=1 and sticky.
REQ-035 SHALL cover: both channels streaming every cycle, tready toggling 1/0 -> no loss, no duplication, in-order pairs, tdata stable while stalled.
REQ-036 SHALL cover: r2=32'h7FC00000 paired with r1=32'h3F800000 -> tuser=1 with macro defined, 0 without.
REQ-037 SHALL cover: three pairs queued, rst_n low for one cycle -> tvalid=0, pair_count=0, skew_err=0, tready=1 on the next cycle, old data never emitted.
REQ-038 SHALL cover: pair_count preloaded by 65535 pops, one more pop -> pair_count=0.

Source files
------------

// File: rtl/float_pkg.sv
// float_pkg: shared FP32 field positions and helpers for the result-pairing block.
// Contents:
//   FP32_W        - width of one FP32 word
//   FP32_EXP_MSB  - most significant bit of the exponent field
//   FP32_EXP_LSB  - least significant bit of the exponent field
//   FP32_EXP_ALL1 - exponent value that marks Inf/NaN
//   is_nan()      - true for an FP32 NaN (exponent all ones, mantissa non-zero)
package float_pkg;

  localparam int         FP32_W        = 32;
  localparam int         FP32_EXP_MSB  = 30;
  localparam int         FP32_EXP_LSB  = 23;
  localparam logic [7:0] FP32_EXP_ALL1 = 8'hFF;

  // Infinity has an all-ones exponent too, so the mantissa must be checked.
  function automatic logic is_nan(input logic [FP32_W-1:0] value);
    is_nan = (value[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL1) &&
             (value[FP32_EXP_LSB-1:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_stream_fifo.sv
// float_stream_fifo: single-clock FIFO holding one channel's results.
// Parameters: DEPTH (power of two, >= 2), WIDTH (data bits).
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   push, push_data    - write request and data (ignored while full)
//   pop                - read request (ignored while empty)
//   head               - oldest entry, valid while not empty
//   full, empty        - occupancy status
module float_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= PW'(0);
      rd_ptr <= PW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/float_result_pair.sv
// float_result_pair: joins two FP32 result streams into {r2, r1} pairs.
// Each channel is buffered in its own float_stream_fifo; a pair is offered
// whenever both FIFOs hold data and both heads are popped together.
// Optional feature: define FLOAT_PAIR_NAN_FLAG_EN to flag NaN heads on tuser.
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   s_axis_r1_* / s_axis_r2_*          - channel result streams (valid/data/ready)
//   m_axis_pair_tvalid/tdata/tready    - paired output stream, tdata = {r2, r1}
//   m_axis_pair_tuser                  - NaN flag (0 when the feature is off)
//   pair_count                         - delivered pairs, wraps at 16 bits
//   skew_err                           - sticky: one FIFO full while the other empty
module float_result_pair
  import float_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_r1_tvalid,
  input  logic [FP32_W-1:0]     s_axis_r1_tdata,
  output logic                  s_axis_r1_tready,
  input  logic                  s_axis_r2_tvalid,
  input  logic [FP32_W-1:0]     s_axis_r2_tdata,
  output logic                  s_axis_r2_tready,
  output logic                  m_axis_pair_tvalid,
  output logic [2*FP32_W-1:0]   m_axis_pair_tdata,
  input  logic                  m_axis_pair_tready,
  output logic                  m_axis_pair_tuser,
  output logic [15:0]           pair_count,
  output logic                  skew_err
);

  logic              push1;
  logic              push2;
  logic              pop;
  logic [FP32_W-1:0] head1;
  logic [FP32_W-1:0] head2;
  logic              full1;
  logic              full2;
  logic              empty1;
  logic              empty2;

  // Ready is forced low during reset so nothing is accepted into a clearing FIFO.
  assign s_axis_r1_tready   = rst_n & ~full1;
  assign s_axis_r2_tready   = rst_n & ~full2;
  assign push1              = s_axis_r1_tvalid & s_axis_r1_tready;
  assign push2              = s_axis_r2_tvalid & s_axis_r2_tready;
  assign m_axis_pair_tvalid = rst_n & ~empty1 & ~empty2;
  assign m_axis_pair_tdata  = {head2, head1};
  assign pop                = m_axis_pair_tvalid & m_axis_pair_tready;

`ifdef FLOAT_PAIR_NAN_FLAG_EN
  assign m_axis_pair_tuser  = m_axis_pair_tvalid & (is_nan(head1) | is_nan(head2));
`else
  assign m_axis_pair_tuser  = 1'b0;
`endif

  float_stream_fifo #(.DEPTH(DEPTH), .WIDTH(FP32_W)) u_fifo_r1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (s_axis_r1_tdata),
    .pop       (pop),
    .head      (head1),
    .full      (full1),
    .empty     (empty1)
  );

  float_stream_fifo #(.DEPTH(DEPTH), .WIDTH(FP32_W)) u_fifo_r2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push2),
    .push_data (s_axis_r2_tdata),
    .pop       (pop),
    .head      (head2),
    .full      (full2),
    .empty     (empty2)
  );

  // Delivered-pair counter and sticky imbalance flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_count <= 16'd0;
      skew_err   <= 1'b0;
    end else begin
      if (pop) begin
        pair_count <= pair_count + 16'd1;
      end
      if ((full1 & empty2) | (full2 & empty1)) begin
        skew_err <= 1'b1;
      end
    end
  end

endmodule
